// File: rtl/data_mem_responder.sv
// Purpose: multi-cycle, byte-addressable data RAM responder for RV32I loads and stores.
// Latency: the response is valid LATENCY cycles after accept. One transaction is in flight at a time.
// Backpressure: req_ready is low while busy; the response holds in RESP until rsp_ready.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_write, req_addr[11:0]         store/load select and byte address
//   req_wdata[31:0], req_funct3[2:0]  store data (low bits) and RV32I width code
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata[31:0], rsp_error        extended load data (0 on store/error), error flag
module data_mem_responder #(
  parameter int NUM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, do_access, do_write;

  // Request fields captured at accept; req_* is ignored afterwards.
  logic          write_q;
  logic [11:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;

  logic [31:0]   mem [NUM_WORDS];
  logic [31:0]   idx_full;
  logic [IW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          legal;
  logic [3:0]    be;
  logic [31:0]   wr_word, load_val;
  logic [31:0]   rdata_d;
  logic          error_d;

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word index wraps modulo the RAM depth, so non-power-of-two depths alias cleanly.
  always_comb begin
    idx_full = 32'(addr_q[11:2]) % NUM_WORDS;
    idx      = idx_full[IW-1:0];
    rd_word  = mem[idx];
    lane_b   = rd_word[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Width decode: legality, byte enables, replicated store data, extended load data.
  always_comb begin
    legal    = 1'b0;
    be       = 4'b0000;
    wr_word  = 32'h0;
    load_val = 32'h0;
    case (funct3_q)
      3'b000: begin
        legal    = 1'b1;
        be       = 4'b0001 << addr_q[1:0];
        wr_word  = {4{wdata_q[7:0]}};
        load_val = {{24{lane_b[7]}}, lane_b};
      end
      3'b001: begin
        legal    = ~addr_q[0];
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{wdata_q[15:0]}};
        load_val = {{16{lane_h[15]}}, lane_h};
      end
      3'b010: begin
        legal    = (addr_q[1:0] == 2'b00);
        be       = 4'b1111;
        wr_word  = wdata_q;
        load_val = rd_word;
      end
      3'b100: begin
        legal    = ~write_q;
        load_val = {24'h0, lane_b};
      end
      3'b101: begin
        legal    = ~write_q & ~addr_q[0];
        load_val = {16'h0, lane_h};
      end
      default: legal = 1'b0;
    endcase
    do_write = do_access & write_q & legal;
    rdata_d  = (legal && !write_q) ? load_val : 32'h0;
    error_d  = ~legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (do_access) begin
        rsp_rdata <= rdata_d;
        rsp_error <= error_d;
      end
    end
  end

  // RAM is not reset. A write only happens on the WAIT->RESP edge, and reset
  // forces IDLE asynchronously, so a dropped store can never reach the array.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: self-checking bench for data_mem_responder.
// Stimulus: a vector table plus hand-written backpressure and reset sequences.
// Expected responses are queued at accept and compared when the response is presented.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  always #5 clk = ~clk;

  data_mem_responder #(.NUM_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic wr, logic [11:0] a, logic [31:0] d, logic [2:0] f,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.f3 = f; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_funct3 = v.f3;
  endtask

  task automatic push_exp(vec_t v);
    exp_t e;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_queue: got empty scoreboard, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_error"}, {31'b0, rsp_error}, {31'b0, e.err});
    end
  endtask

  // Bounded wait for rsp_valid; optionally throws ignored garbage requests meanwhile.
  task automatic wait_rsp(input bit garbage, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (garbage) begin
        req_valid  = 1'b1;
        req_write  = 1'($urandom);
        req_addr   = 12'($urandom);
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
      end
      tick;
      lat++;
    end
    req_valid = 1'b0;
  endtask

  task automatic run_txn(vec_t v, string tag);
    int lat;
    drive(v);
    rsp_ready = 1'b1;
    tick;                                   // accept edge
    push_exp(v);
    check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    wait_rsp(1'b1, lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    pop_check(tag);
    tick;                                   // handshake edge
    check({tag, "_idle"}, {30'b0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    int   lat;
    vec_t v;

    // wr, addr, wdata, funct3, expected rdata, expected error
    vecs.push_back(mk(1, 12'h010, 32'hDEADBEEF, 3'd2, 32'h0,        0)); // SW
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd2, 32'hDEADBEEF, 0)); // LW
    vecs.push_back(mk(1, 12'h013, 32'h00000080, 3'd0, 32'h0,        0)); // SB
    vecs.push_back(mk(0, 12'h013, 32'h0,        3'd0, 32'hFFFFFF80, 0)); // LB
    vecs.push_back(mk(0, 12'h013, 32'h0,        3'd4, 32'h00000080, 0)); // LBU
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd2, 32'h80ADBEEF, 0)); // LW
    vecs.push_back(mk(1, 12'h012, 32'hFFFF1234, 3'd1, 32'h0,        0)); // SH
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd2, 32'h1234BEEF, 0)); // LW
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd1, 32'hFFFFBEEF, 0)); // LH
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd5, 32'h0000BEEF, 0)); // LHU
    vecs.push_back(mk(0, 12'h012, 32'h0,        3'd1, 32'h00001234, 0)); // LH upper
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd0, 32'hFFFFFFEF, 0)); // LB lane 0
    vecs.push_back(mk(0, 12'h011, 32'h0,        3'd4, 32'h000000BE, 0)); // LBU lane 1
    vecs.push_back(mk(0, 12'h011, 32'h0,        3'd2, 32'h0,        1)); // LW misaligned
    vecs.push_back(mk(1, 12'h011, 32'h0000FFFF, 3'd1, 32'h0,        1)); // SH misaligned
    vecs.push_back(mk(1, 12'h012, 32'hFFFFFFFF, 3'd2, 32'h0,        1)); // SW misaligned
    vecs.push_back(mk(0, 12'h013, 32'h0,        3'd5, 32'h0,        1)); // LHU misaligned
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd3, 32'h0,        1)); // load f3=3
    vecs.push_back(mk(1, 12'h010, 32'h0,        3'd4, 32'h0,        1)); // store f3=4
    vecs.push_back(mk(1, 12'h010, 32'h0,        3'd5, 32'h0,        1)); // store f3=5
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd7, 32'h0,        1)); // load f3=7
    vecs.push_back(mk(0, 12'h010, 32'h0,        3'd2, 32'h1234BEEF, 0)); // unchanged
    vecs.push_back(mk(1, 12'h020, 32'h0,        3'd2, 32'h0,        0)); // zero 0x020
    vecs.push_back(mk(0, 12'h020, 32'h0,        3'd2, 32'h0,        0));

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    tick; tick;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_error", {31'b0, rsp_error}, 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held 5 cycles while a second request waits.
    v = mk(0, 12'h010, 32'h0, 3'd2, 32'h1234BEEF, 0);
    drive(v);
    rsp_ready = 1'b0;
    tick;
    push_exp(v);
    req_valid = 1'b0;
    wait_rsp(1'b0, lat);
    check("bp_lat", 32'(lat), 32'(LAT));
    v = mk(1, 12'h010, 32'hCAFEF00D, 3'd2, 32'h0, 0);
    drive(v);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d_valid", k), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'h1234BEEF);
      check($sformatf("bp_hold%0d_ready", k), {31'b0, req_ready}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    pop_check("bp_first");
    tick;                                   // handshake edge M
    check("bp_after_hs", {30'b0, req_ready, rsp_valid}, 32'd2);
    tick;                                   // accept edge M+1
    push_exp(v);
    check("bp_accept_m1", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_rsp(1'b0, lat);
    check("bp_second_lat", 32'(lat), 32'(LAT));
    pop_check("bp_second");
    tick;
    run_txn(mk(0, 12'h010, 32'h0, 3'd2, 32'hCAFEF00D, 0), "bp_readback");

    // Reset during WAIT of a store: dropped, RAM untouched, outputs cleared.
    drive(mk(1, 12'h020, 32'hA5A5A5A5, 3'd2, 32'h0, 0));
    rsp_ready = 1'b1;
    tick;                                   // accepted, now in WAIT
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    tick; tick; tick;
    rst = 1'b0;
    tick;
    run_txn(mk(0, 12'h020, 32'h0, 3'd2, 32'h0, 0), "rst_readback");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
